us_scan_scheduler: RTL

- Sequences a bank of N_SENS ultrasonic ranging units. Each unit has an init/done/9-bit-distance handshake, and the units share one acoustic space.
- Fires one sensor at a time in round-robin order over an enable mask, with a guard interval between shots to avoid crosstalk.
- Keeps the latest distance for each sensor and flags obstacles against a threshold.
- Sits between the ranging units and the robot navigation/CSR logic.

---
 rtl/us_scan_scheduler_if.sv | 21 ++
 rtl/us_scan_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/us_scan_scheduler_if.sv
// Handshake bundle between the scan scheduler and its bank of ultrasonic ranging units.
// Unit i drives its 9-bit distance on meas_dist[9i+8:9i].
interface us_scan_scheduler_if #(
    parameter int N_SENS = 3
);
    logic [N_SENS-1:0]   meas_init;
    logic [N_SENS-1:0]   meas_done;
    logic [9*N_SENS-1:0] meas_dist;

    modport master (
        output meas_init,
        input  meas_done,
        input  meas_dist
    );

    modport slave (
        input  meas_init,
        output meas_done,
        output meas_dist
    );
endinterface

// File: rtl/us_scan_scheduler.sv
// Round-robin scheduler for a bank of ultrasonic ranging units that share one acoustic space.
// Fires one unit at a time with a guard interval, stores each distance and flags obstacles.
module us_scan_scheduler #(
    parameter int N_SENS     = 3,
    parameter int CLK_HZ     = 100000000,
    parameter int INIT_US    = 3,
    parameter int TIMEOUT_US = 30000,
    parameter int GUARD_US   = 60000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable_i,
    input  logic                single_i,
    input  logic                start_i,
    input  logic [N_SENS-1:0]   mask_i,
    input  logic [8:0]          obst_thr_i,
    us_scan_scheduler_if.master bus,
    output logic [9*N_SENS-1:0] dist_out_o,
    output logic [N_SENS-1:0]   valid_o,
    output logic [N_SENS-1:0]   timeout_err_o,
    output logic [N_SENS-1:0]   obstacle_o,
    output logic [1:0]          cur_sel_o,
    output logic                busy_o,
    output logic                scan_done_o
);

    localparam int PRE_CNT  = (CLK_HZ / 1000000 > 0) ? (CLK_HZ / 1000000) : 1;
    localparam int PRE_W    = (PRE_CNT > 1) ? $clog2(PRE_CNT) : 1;
    localparam int US_MAX_A = (INIT_US > TIMEOUT_US) ? INIT_US : TIMEOUT_US;
    localparam int US_MAX   = (US_MAX_A > GUARD_US) ? US_MAX_A : GUARD_US;
    localparam int US_W     = $clog2(US_MAX + 1);

    localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(PRE_CNT - 1);
    localparam logic [US_W-1:0]  US_SAT       = {US_W{1'b1}};
    localparam logic [US_W-1:0]  INIT_LAST    = US_W'(INIT_US - 1);
    localparam logic [US_W-1:0]  TIMEOUT_LAST = US_W'(TIMEOUT_US - 1);
    localparam logic [US_W-1:0]  GUARD_LAST   = US_W'(GUARD_US - 1);
    localparam logic [8:0]       DIST_NONE    = 9'd511;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_GUARD  = 3'd4,
        ST_NEXT   = 3'd5
    } state_t;

    // Returns {found, index} of the next set mask bit; search starts at 0 on the first sweep.
    function automatic logic [2:0] pick_next(input logic [N_SENS-1:0] m,
                                             input logic [1:0] cur,
                                             input logic first);
        int         cand;
        logic       found;
        logic       hit;
        logic [1:0] idx;
        found = 1'b0;
        idx   = 2'd0;
        for (int k = 0; k < N_SENS; k++) begin
            cand  = first ? k : ((int'(cur) + 1 + k) % N_SENS);
            hit   = ~found & m[cand];
            idx   = hit ? 2'(cand) : idx;
            found = found | m[cand];
        end
        return {found, idx};
    endfunction

    function automatic logic any_after(input logic [N_SENS-1:0] m, input logic [1:0] cur);
        logic any;
        any = 1'b0;
        for (int i = 0; i < N_SENS; i++) begin
            any = any | ((i > int'(cur)) & m[i]);
        end
        return any;
    endfunction

    function automatic logic [N_SENS-1:0] onehot(input logic [1:0] idx);
        logic [N_SENS-1:0] v;
        for (int i = 0; i < N_SENS; i++) begin
            v[i] = (i == int'(idx));
        end
        return v;
    endfunction

    state_t              state_q;
    logic [PRE_W-1:0]    pre_q;
    logic [US_W-1:0]     us_q;
    logic [N_SENS-1:0]   done_s1_q;
    logic [N_SENS-1:0]   done_s2_q;
    logic [N_SENS-1:0]   done_prev_q;
    logic [N_SENS-1:0]   meas_init_q;
    logic [9*N_SENS-1:0] dist_q;
    logic [N_SENS-1:0]   valid_q;
    logic [N_SENS-1:0]   terr_q;
    logic [N_SENS-1:0]   obst_q;
    logic [1:0]          cur_sel_q;
    logic                busy_q;
    logic                scan_done_q;
    logic                first_q;

    logic                tick_s;
    logic [N_SENS-1:0]   rise_s;
    logic [2:0]          pick_s;
    logic                wrap_s;
    logic [8:0]          cap_s;

    assign tick_s = (pre_q == PRE_LAST);
    assign rise_s = done_s2_q & ~done_prev_q;
    assign pick_s = pick_next(mask_i, cur_sel_q, first_q);
    assign wrap_s = ~any_after(mask_i, cur_sel_q);
    assign cap_s  = bus.meas_dist[9*int'(cur_sel_q) +: 9];

    assign bus.meas_init = meas_init_q;
    assign dist_out_o    = dist_q;
    assign valid_o       = valid_q;
    assign timeout_err_o = terr_q;
    assign obstacle_o    = obst_q;
    assign cur_sel_o     = cur_sel_q;
    assign busy_o        = busy_q;
    assign scan_done_o   = scan_done_q;

    // Scan FSM with prescaler, us counter, done synchronizers and per-sensor result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pre_q       <= '0;
            us_q        <= '0;
            done_s1_q   <= '0;
            done_s2_q   <= '0;
            done_prev_q <= '0;
            meas_init_q <= '0;
            dist_q      <= '0;
            valid_q     <= '0;
            terr_q      <= '0;
            obst_q      <= '0;
            cur_sel_q   <= 2'd0;
            busy_q      <= 1'b0;
            scan_done_q <= 1'b0;
            first_q     <= 1'b1;
        end else begin
            done_s1_q   <= bus.meas_done;
            done_s2_q   <= done_s1_q;
            done_prev_q <= done_s2_q;
            scan_done_q <= 1'b0;

            if (tick_s) begin
                pre_q <= '0;
                if (us_q != US_SAT) begin
                    us_q <= us_q + 1'b1;
                end
            end else begin
                pre_q <= pre_q + 1'b1;
            end

            // Threshold follows obst_thr every cycle; a capture below overrides its own slot.
            for (int i = 0; i < N_SENS; i++) begin
                obst_q[i] <= valid_q[i] & (dist_q[9*i +: 9] < obst_thr_i);
            end

            case (state_q)
                ST_IDLE: begin
                    if (enable_i && (|mask_i) && (!single_i || start_i)) begin
                        state_q <= ST_SELECT;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SELECT: begin
                    if (pick_s[2]) begin
                        cur_sel_q   <= pick_s[1:0];
                        first_q     <= 1'b0;
                        pre_q       <= '0;
                        us_q        <= '0;
                        meas_init_q <= onehot(pick_s[1:0]);
                        state_q     <= ST_LAUNCH;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    if (tick_s && (us_q == INIT_LAST)) begin
                        meas_init_q <= '0;
                        pre_q       <= '0;
                        us_q        <= '0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // An echo landing on the timeout cycle still counts as a measurement.
                    if (rise_s[cur_sel_q]) begin
                        dist_q[9*int'(cur_sel_q) +: 9] <= cap_s;
                        valid_q[cur_sel_q]             <= 1'b1;
                        terr_q[cur_sel_q]              <= 1'b0;
                        obst_q[cur_sel_q]              <= (cap_s < obst_thr_i);
                        pre_q                          <= '0;
                        us_q                           <= '0;
                        state_q                        <= ST_GUARD;
                    end else if (tick_s && (us_q == TIMEOUT_LAST)) begin
                        dist_q[9*int'(cur_sel_q) +: 9] <= DIST_NONE;
                        valid_q[cur_sel_q]             <= 1'b0;
                        terr_q[cur_sel_q]              <= 1'b1;
                        obst_q[cur_sel_q]              <= 1'b0;
                        pre_q                          <= '0;
                        us_q                           <= '0;
                        state_q                        <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    if (tick_s && (us_q == GUARD_LAST)) begin
                        state_q <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    scan_done_q <= wrap_s;
                    if ((wrap_s && single_i) || !enable_i || (mask_i == '0)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_SELECT;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    meas_init_q <= '0;
                end
            endcase
        end
    end

endmodule
